// File: rtl/nco_clk_en_gen_if.sv
// Configuration handshake bus for nco_clk_en_gen: per-channel step updates
// with a valid/ready transfer and an invalid-channel error pulse.
interface nco_clk_en_gen_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned ACC_W    = 24
);
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [ACC_W-1:0] cfg_step;
   logic             cfg_err;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_step,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_step,
      output cfg_ready,
      output cfg_err
   );
endinterface

// File: rtl/nco_clk_en_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// glitch-free step updates at wrap. Optional PHASE_ALIGN_EN adds a sync_in phase reset.
module nco_clk_en_gen #(
   parameter int unsigned      CHANNELS    = 2,
   parameter int unsigned      ACC_W       = 24,
   parameter logic [ACC_W-1:0] DEF_STEP    = 24'h555555,
   parameter int unsigned      LOCK_CYCLES = 256
) (
   input  logic                clkin,
   input  logic                rst_n,
`ifdef PHASE_ALIGN_EN
   input  logic                sync_in,
`endif
   nco_clk_en_gen_if.slave     cfg,
   output logic [CHANNELS-1:0] ce,
   output logic [CHANNELS-1:0] tog,
   output logic                locked
);
   localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   typedef enum logic [0:0] {StIdle, StPend} state_e;

   state_e                         state_q;
   logic                           ready_q;
   logic                           err_q;
   logic                           locked_q;
   logic [LCNT_W-1:0]              lcnt_q;
   logic [CH_W-1:0]                pend_ch_q;
   logic [ACC_W-1:0]               pend_step_q;
   logic [CHANNELS-1:0][ACC_W-1:0] acc_q;
   logic [CHANNELS-1:0][ACC_W-1:0] step_q;
   logic [CHANNELS-1:0][ACC_W:0]   sum;
   logic [CHANNELS-1:0]            carry;
   logic                           sync;
   logic                           accept;
   logic                           ch_ok;
   logic                           apply;

`ifdef PHASE_ALIGN_EN
   assign sync = sync_in;
`else
   assign sync = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         sum[i]   = {1'b0, acc_q[i]} + {1'b0, step_q[i]};
         // A phase realignment suppresses this cycle's wrap.
         carry[i] = sum[i][ACC_W] & ~sync;
      end
   end

   assign accept = cfg.cfg_valid & ready_q;
   assign ch_ok  = 32'(cfg.cfg_ch) < CHANNELS;
   // A stopped channel never wraps, so its new step is taken straight away.
   assign apply  = (state_q == StPend) &
                   (carry[pend_ch_q] | (step_q[pend_ch_q] == '0));

   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         acc_q  <= '0;
         step_q <= {CHANNELS{DEF_STEP}};
         ce     <= '0;
         tog    <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync) begin
               acc_q[i] <= '0;
               ce[i]    <= 1'b0;
               tog[i]   <= 1'b0;
            end else begin
               acc_q[i] <= sum[i][ACC_W-1:0];
               ce[i]    <= carry[i];
               tog[i]   <= tog[i] ^ carry[i];
            end
            if (apply && (pend_ch_q == CH_W'(i))) begin
               step_q[i] <= pend_step_q;
            end
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         locked_q    <= 1'b0;
         lcnt_q      <= '0;
         pend_ch_q   <= '0;
         pend_step_q <= '0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b1;
               if (accept && ch_ok) begin
                  pend_ch_q   <= cfg.cfg_ch;
                  pend_step_q <= cfg.cfg_step;
                  state_q     <= StPend;
                  ready_q     <= 1'b0;
                  locked_q    <= 1'b0;
                  lcnt_q      <= '0;
               end else begin
                  if (accept) begin
                     err_q <= 1'b1;
                  end
                  if (lcnt_q == LCNT_W'(LOCK_CYCLES - 1)) begin
                     locked_q <= 1'b1;
                  end else begin
                     lcnt_q <= lcnt_q + 1'b1;
                  end
               end
            end
            StPend: begin
               if (apply) begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_err   = err_q;
   assign locked        = locked_q;

endmodule

// File: tb/tb_nco_clk_en_gen.sv
// Randomized bench for nco_clk_en_gen against a running-total reference model.
module tb_nco_clk_en_gen;
   localparam int unsigned CHANNELS    = 3;
   localparam int unsigned ACC_W       = 8;
   localparam int unsigned LOCK_CYCLES = 4;
   localparam int unsigned DEF_STEP    = 64;
   localparam longint      MODULUS     = 64'd1 << ACC_W;

   logic                clkin = 1'b0;
   logic                rst_n = 1'b0;
   logic                sync_in = 1'b0;
   logic [CHANNELS-1:0] ce;
   logic [CHANNELS-1:0] tog;
   logic                locked;

   int n_cmp = 0;
   int n_bad = 0;

   nco_clk_en_gen_if #(.CHANNELS(CHANNELS), .ACC_W(ACC_W)) cfg_if ();

   nco_clk_en_gen #(
      .CHANNELS    (CHANNELS),
      .ACC_W       (ACC_W),
      .DEF_STEP    (ACC_W'(DEF_STEP)),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .clkin   (clkin),
      .rst_n   (rst_n),
`ifdef PHASE_ALIGN_EN
      .sync_in (sync_in),
`endif
      .cfg     (cfg_if.slave),
      .ce      (ce),
      .tog     (tog),
      .locked  (locked)
   );

   always #5 clkin = ~clkin;

   // Reference: each channel keeps the unbounded running sum of its steps;
   // an enable fires whenever that sum crosses a multiple of 2^ACC_W.
   longint      tot   [CHANNELS];
   int unsigned mstep [CHANNELS];
   bit          mce   [CHANNELS];
   bit          mtog  [CHANNELS];
   bit          mpend;
   int          mpch;
   int unsigned mpstep;
   int          midle_cnt;
   bit          mready;
   bit          merr;
   bit          m_acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_edge();
      bit wrap [CHANNELS];
      m_acc = 1'b0;
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            tot[c] = 0; mstep[c] = DEF_STEP; mce[c] = 0; mtog[c] = 0;
         end
         mpend = 0; mready = 0; merr = 0; midle_cnt = 0;
         return;
      end
      for (int c = 0; c < CHANNELS; c++) begin
         wrap[c] = !sync_in && (((tot[c] + mstep[c]) / MODULUS) != (tot[c] / MODULUS));
         if (sync_in) begin
            tot[c] = 0; mce[c] = 0; mtog[c] = 0;
         end else begin
            tot[c] = tot[c] + mstep[c]; mce[c] = wrap[c]; mtog[c] = mtog[c] ^ wrap[c];
         end
      end
      merr = 0;
      if (mpend) begin
         if (wrap[mpch] || mstep[mpch] == 0) begin
            mstep[mpch] = mpstep;
            mpend = 0;
         end
      end else begin
         m_acc = cfg_if.cfg_valid && mready;
         if (m_acc && int'(cfg_if.cfg_ch) < CHANNELS) begin
            mpend = 1; mpch = int'(cfg_if.cfg_ch); mpstep = cfg_if.cfg_step; midle_cnt = 0;
         end else begin
            if (m_acc) merr = 1;
            midle_cnt++;
         end
      end
      mready = !mpend;
   endtask

   task automatic tick();
      logic [CHANNELS-1:0] e_ce;
      logic [CHANNELS-1:0] e_tog;
      @(posedge clkin);
      model_edge();
      #1;
      for (int c = 0; c < CHANNELS; c++) begin
         e_ce[c] = mce[c]; e_tog[c] = mtog[c];
      end
      check("ce", 32'(ce), 32'(e_ce));
      check("tog", 32'(tog), 32'(e_tog));
      check("locked", 32'(locked), 32'(midle_cnt >= LOCK_CYCLES));
      check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(mready));
      check("cfg_err", 32'(cfg_if.cfg_err), 32'(merr));
   endtask

   task automatic do_cfg(input int ch, input int unsigned stp);
      int n = 0;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'(ch);
      cfg_if.cfg_step  = ACC_W'(stp);
      do begin
         tick();
         n++;
      end while (!m_acc && n < 1000);
      cfg_if.cfg_valid = 1'b0;
      if (!m_acc) check("cfg_accept_timeout", 32'(m_acc), 32'd1);
   endtask

   task automatic wait_apply();
      int n = 0;
      while (mpend && n < 1000) begin
         tick();
         n++;
      end
      if (mpend) check("apply_timeout", 32'(mpend), 32'd0);
   endtask

   function automatic int unsigned pick_step();
      case ($urandom_range(0, 6))
         0:       return 0;
         1:       return 1;
         2:       return 64;
         3:       return 85;
         4:       return 128;
         5:       return 255;
         default: return $urandom_range(1, 255);
      endcase
   endfunction

   initial begin
      int cnt;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_step  = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (12) tick();

      // 256 cycles at step 85 must yield exactly 85 enables whatever the phase.
      do_cfg(0, 85);
      wait_apply();
      cnt = 0;
      for (int k = 0; k < 256; k++) begin
         tick();
         cnt += int'(ce[0]);
      end
      check("ce0_count_step85", 32'(cnt), 32'd85);

      // Stop a channel, then a back-to-back request that must wait for ready.
      do_cfg(1, 0);
      do_cfg(1, 64);
      wait_apply();
      do_cfg(3, 128);
      repeat (8) tick();

      for (int t = 0; t < 80; t++) begin
         repeat ($urandom_range(0, 12)) begin
`ifdef PHASE_ALIGN_EN
            sync_in = ($urandom_range(0, 14) == 0);
`endif
            tick();
         end
         sync_in = 1'b0;
         do_cfg(int'($urandom_range(0, 3)), pick_step());
         if ($urandom_range(0, 9) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
      end
      sync_in = 1'b0;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
